// File: rtl/ycc_mcu_sequencer.sv
// rtl/ycc_mcu_sequencer.sv - IDCT-to-colour-conversion MCU sequencer with two-bank pixel buffer
//
// Accepts one 4:4:4 MCU as 192 signed IDCT samples (64 Y, 64 Cb, 64 Cr, raster
// order), level-shifts by +128 and clamps to 0..255, stores them in one of two
// banks, then streams per-pixel {Y, Cb, Cr} triples zero-extended to DATA_W.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of bank flags and all pointers
//   in_valid/in_ready/in_data     sample input handshake (signed sample)
//   out_valid/out_ready           pixel output handshake
//   out_y/out_cb/out_cr           component values 0..255, zero-extended
//   out_last        marks pixel 63 of the current MCU
//   mcu_count       MCUs fully emitted, wraps

module ycc_mcu_sequencer #(
  parameter int DATA_W    = 32,
  parameter int MCU_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_y,
  output logic [DATA_W-1:0]    out_cb,
  output logic [DATA_W-1:0]    out_cr,
  output logic                 out_last,
  output logic [MCU_CNT_W-1:0] mcu_count
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } rd_state_t;

  localparam logic signed [DATA_W:0] LEVEL_BIAS = (DATA_W+1)'(128);

  rd_state_t            state_q, state_d;
  logic                 run_q;
  logic [1:0]           full_q, full_d, full_set, full_clr;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [7:0]           wr_cnt_q, wr_cnt_d;
  logic [5:0]           rd_idx_q, rd_idx_d;
  logic [7:0]           y_q, y_d, cb_q, cb_d, cr_q, cr_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [MCU_CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]           mem0 [0:191];
  logic [7:0]           mem1 [0:191];

  logic                 wr_fire;
  logic                 rd_fire;
  logic signed [DATA_W:0] biased;
  logic [7:0]           clamped;

  logic                 load;
  logic                 load_bank;
  logic [5:0]           load_idx;
  logic [7:0]           addr_y, addr_cb, addr_cr;

  // run_q keeps in_ready low during reset and lets it rise on the first edge
  // after release; flush leaves it set.
  assign in_ready  = run_q & ~full_q[wr_bank_q];
  assign wr_fire   = in_valid & in_ready & ~flush;
  assign rd_fire   = valid_q & out_ready;

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_y     = {{(DATA_W-8){1'b0}}, y_q};
  assign out_cb    = {{(DATA_W-8){1'b0}}, cb_q};
  assign out_cr    = {{(DATA_W-8){1'b0}}, cr_q};
  assign mcu_count = cnt_q;

  // Sign-extend by one bit before biasing so the most negative/positive
  // samples cannot wrap around into the 0..255 window.
  assign biased = $signed({in_data[DATA_W-1], in_data}) + LEVEL_BIAS;

  always_comb begin
    clamped = biased[7:0];
    if (biased[DATA_W]) begin
      clamped = 8'd0;
    end else if (|biased[DATA_W-1:8]) begin
      clamped = 8'd255;
    end
  end

  // Sample storage carries no reset: contents are only ever read from a bank
  // whose full flag was set by a complete write pass.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank_q) begin
        mem1[wr_cnt_q] <= clamped;
      end else begin
        mem0[wr_cnt_q] <= clamped;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    y_d       = y_q;
    cb_d      = cb_q;
    cr_d      = cr_q;
    valid_d   = valid_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    full_set  = 2'b00;
    full_clr  = 2'b00;
    load      = 1'b0;
    load_bank = rd_bank_q;
    load_idx  = 6'd0;
    addr_y    = 8'd0;
    addr_cb   = 8'd0;
    addr_cr   = 8'd0;

    // Write side
    if (wr_fire) begin
      if (wr_cnt_q == 8'd191) begin
        full_set[wr_bank_q] = 1'b1;
        wr_cnt_d            = 8'd0;
        wr_bank_d           = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
    end

    // Read side
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load      = 1'b1;
          load_bank = rd_bank_q;
          load_idx  = 6'd0;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_fire) begin
          if (rd_idx_q == 6'd63) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            cnt_d               = cnt_q + {{(MCU_CNT_W-1){1'b0}}, 1'b1};
            // Chain straight into the other bank when it is already full so
            // consecutive MCUs stream without a bubble.
            if (full_q[~rd_bank_q]) begin
              load      = 1'b1;
              load_bank = ~rd_bank_q;
              load_idx  = 6'd0;
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            load      = 1'b1;
            load_bank = rd_bank_q;
            load_idx  = rd_idx_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      addr_y   = {2'b00, load_idx};
      addr_cb  = 8'd64 + {2'b00, load_idx};
      addr_cr  = 8'd128 + {2'b00, load_idx};
      y_d      = load_bank ? mem1[addr_y]  : mem0[addr_y];
      cb_d     = load_bank ? mem1[addr_cb] : mem0[addr_cb];
      cr_d     = load_bank ? mem1[addr_cr] : mem0[addr_cr];
      valid_d  = 1'b1;
      last_d   = (load_idx == 6'd63);
      rd_idx_d = load_idx;
    end

    // A bank being set by the writer is never the one the reader clears.
    full_d = (full_q & ~full_clr) | full_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 8'd0;
      rd_idx_q  <= 6'd0;
      y_q       <= 8'd0;
      cb_q      <= 8'd0;
      cr_q      <= 8'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b1;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 8'd0;
      rd_idx_q  <= 6'd0;
      y_q       <= 8'd0;
      cb_q      <= 8'd0;
      cr_q      <= 8'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      y_q       <= y_d;
      cb_q      <= cb_d;
      cr_q      <= cr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ycc_mcu_sequencer.sv
// tb/tb_ycc_mcu_sequencer.sv - self-checking bench for ycc_mcu_sequencer

module tb_ycc_mcu_sequencer;

  typedef struct {
    logic [31:0] sample;
    logic [7:0]  exp_byte;
  } clamp_vec_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       last;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y, out_cb, out_cr;
  logic        out_last;
  logic [15:0] mcu_count;

  int          checks = 0;
  int          errors = 0;
  int          pix_cnt = 0;
  int          rdy_mode = 0;
  int          rdy_ph = 0;
  bit          stop_prod = 0;
  bit          prod_done = 0;
  bit          stall_prev = 0;
  logic [96:0] hold_val;
  pix_t        exp_q[$];
  logic [7:0]  cap_y[$];
  pix_t        mon_e;
  clamp_vec_t  cv[12];

  ycc_mcu_sequencer #(.DATA_W(32), .MCU_CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cb    (out_cb),
    .out_cr    (out_cr),
    .out_last  (out_last),
    .mcu_count (mcu_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // out_ready modes: 0 = always 1, 1 = always 0, 2 = pattern 1,0,0,1
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: begin
        out_ready = (rdy_ph == 0) || (rdy_ph == 3);
        rdy_ph    = (rdy_ph + 1) % 4;
      end
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || {out_y, out_cb, out_cr, out_last} !== hold_val) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b %h required valid=1 %h",
                   out_valid, {out_y, out_cb, out_cr, out_last}, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got y=%0h cb=%0h cr=%0h with empty scoreboard",
                   out_y, out_cb, out_cr);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_y !== {24'd0, mon_e.y} || out_cb !== {24'd0, mon_e.cb} ||
              out_cr !== {24'd0, mon_e.cr} || out_last !== mon_e.last) begin
            errors++;
            $display("FAIL pixel %0d: got y=%0h cb=%0h cr=%0h last=%0b required y=%0h cb=%0h cr=%0h last=%0b",
                     pix_cnt, out_y, out_cb, out_cr, out_last, mon_e.y, mon_e.cb, mon_e.cr, mon_e.last);
          end
        end
        cap_y.push_back(out_y[7:0]);
        pix_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      hold_val   = {out_y, out_cb, out_cr, out_last};
    end else begin
      stall_prev = 0;
    end
  end

  function automatic logic [7:0] ref_clamp(input int v);
    if (v < -128) return 8'd0;
    if (v > 127)  return 8'd255;
    return 8'(v + 128);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_sample(input logic [31:0] d);
    int n;
    if (stop_prod) return;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && !stop_prod) begin
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 3000 cycles");
        stop_prod = 1;
      end
      @(negedge clk);
    end
    if (!stop_prod) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_mcu(input int kind);
    int   s[192];
    pix_t e;
    for (int i = 0; i < 192; i++) begin
      case (kind)
        0: s[i] = (i < 64) ? i - 64 : ((i < 128) ? 0 : -128);
        1: begin
          if (i < 12)       s[i] = int'($signed(cv[i].sample));
          else if (i < 64)  s[i] = i * 4 - 128;
          else if (i < 128) s[i] = i * 7 - 600;
          else              s[i] = 1400 - i * 9;
        end
        default: s[i] = int'($urandom_range(700, 0)) - 350;
      endcase
    end
    for (int p = 0; p < 64; p++) begin
      e.y    = ref_clamp(s[p]);
      e.cb   = ref_clamp(s[64 + p]);
      e.cr   = ref_clamp(s[128 + p]);
      e.last = (p == 63);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 192; i++) push_sample(32'(s[i]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pixels outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_prod();
    int n;
    n = 0;
    while (!prod_done && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk("producer_done", 64'(prod_done), 64'd1);
    #1;
  endtask

  initial begin
    int base;
    int n;
    int nx;

    cv[0]  = '{32'hFFFF_FF38, 8'd0};    // -200
    cv[1]  = '{32'hFFFF_FF7F, 8'd0};    // -129
    cv[2]  = '{32'hFFFF_FF80, 8'd0};    // -128
    cv[3]  = '{32'h0000_007F, 8'd255};  // 127
    cv[4]  = '{32'h0000_0080, 8'd255};  // 128
    cv[5]  = '{32'h0000_03E8, 8'd255};  // 1000
    cv[6]  = '{32'h8000_0000, 8'd0};    // most negative
    cv[7]  = '{32'hFFFF_FFFF, 8'd127};  // -1
    cv[8]  = '{32'h0000_0000, 8'd128};
    cv[9]  = '{32'h0000_0005, 8'd133};
    cv[10] = '{32'h0000_007E, 8'd254};
    cv[11] = '{32'h7FFF_FFFF, 8'd255};  // most positive

    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_y", 64'(out_y), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_mcu_count", 64'(mcu_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Single MCU and first-output latency
    send_mcu(0);
    chk("latency_before", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_pixel0_y", 64'(out_y), 64'd64);
    drain();
    chk("single_mcu_count", 64'(mcu_count), 64'd1);
    chk("single_idle", 64'(out_valid), 64'd0);

    // Clamp table
    cap_y.delete();
    send_mcu(1);
    drain();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= cap_y.size() || cap_y[i] !== cv[i].exp_byte) begin
        errors++;
        $display("FAIL clamp[%0d] sample %h: got %0h required %0h", i, cv[i].sample,
                 (i < cap_y.size()) ? cap_y[i] : 8'hxx, cv[i].exp_byte);
      end
    end
    chk("clamp_mcu_count", 64'(mcu_count), 64'd2);

    // Backpressure pattern 1,0,0,1
    rdy_mode = 2;
    send_mcu(2);
    send_mcu(2);
    drain();
    chk("bp_mcu_count", 64'(mcu_count), 64'd4);

    // Both banks full, then gapless back-to-back streaming
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_mcu(2);
    send_mcu(2);
    chk("both_full_in_ready", 64'(in_ready), 64'd0);
    chk("both_full_valid", 64'(out_valid), 64'd1);
    prod_done = 0;
    fork
      begin
        send_mcu(2);
        prod_done = 1;
      end
    join_none
    rdy_mode = 0;
    n = 0;
    @(negedge clk);
    while (!out_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    nx = 0;
    for (int i = 0; i < 128; i++) begin
      if (out_valid && out_ready) nx++;
      if (i == 63) chk("in_ready_held_low", 64'(in_ready), 64'd0);
      if (i == 64) chk("in_ready_released", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    chk("b2b_no_gap_xfers", 64'(nx), 64'd128);
    wait_prod();
    drain();
    chk("b2b_mcu_count", 64'(mcu_count), 64'd7);

    // Flush mid-stream
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_mcu(2);
    for (int i = 0; i < 100; i++) push_sample(32'(i * 3 - 150));
    rdy_mode = 0;
    base = pix_cnt;
    n = 0;
    while (pix_cnt < base + 30 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("flush_reached_px30", 64'(pix_cnt - base >= 30), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_mcu_count", 64'(mcu_count), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    send_mcu(0);
    drain();
    chk("post_flush_mcu_count", 64'(mcu_count), 64'd1);

    // Asynchronous reset in the middle of a transfer
    prod_done = 0;
    fork
      begin
        send_mcu(2);
        send_mcu(2);
        prod_done = 1;
      end
    join_none
    repeat (200) @(posedge clk);
    #3;
    chk("pre_reset_streaming", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_mcu_count", 64'(mcu_count), 64'd0);
    stop_prod = 1;
    wait_prod();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stop_prod = 0;
    @(posedge clk);
    #1;
    chk("restart_in_ready", 64'(in_ready), 64'd1);
    chk("restart_out_valid", 64'(out_valid), 64'd0);
    send_mcu(0);
    drain();
    chk("restart_mcu_count", 64'(mcu_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
